// File: rtl/el2_ic_debug_seq_pkg.sv
// Shared types for the icache debug (dicago) access sequencer.
package el2_ic_debug_seq_pkg;

  // Defaults for the abandon timeout and its counter width.
  localparam int EL2_IC_DBG_TIMEOUT_CYC = 255;
  localparam int EL2_IC_DBG_TO_W        = 16;

  localparam int EL2_IC_DICAWICS_W = 17;
  localparam int EL2_IC_WRDATA_W   = 71;

  // Debug packet to the IFU: {wrdata, dicawics, rd_valid, wr_valid} = 90 bits.
  typedef struct packed {
    logic [EL2_IC_WRDATA_W-1:0]   icache_wrdata;
    logic [EL2_IC_DICAWICS_W-1:0] icache_dicawics;
    logic                         icache_rd_valid;
    logic                         icache_wr_valid;
  } el2_cache_debug_pkt_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } el2_ic_dbg_state_t;

  // Latched request as captured at acceptance.
  typedef struct packed {
    logic                         write;
    logic [EL2_IC_DICAWICS_W-1:0] dicawics;
    logic [EL2_IC_WRDATA_W-1:0]   wrdata;
  } el2_ic_dbg_req_t;

  // Latched response held until the CSR unit consumes it.
  typedef struct packed {
    logic                       err;
    logic [EL2_IC_WRDATA_W-1:0] rddata;
  } el2_ic_dbg_rsp_t;

endpackage

// File: rtl/el2_ic_debug_seq_tmr.sv
// WAIT-state timeout counter: synchronous clear, count enable, expiry flag.
module el2_ic_debug_seq_tmr
  import el2_ic_debug_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = EL2_IC_DBG_TIMEOUT_CYC,
  parameter int TO_W        = EL2_IC_DBG_TO_W
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // Last count value before the access is abandoned.
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + TO_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/el2_ic_debug_seq.sv
// Icache debug access sequencer: accepts one dicago request, pulses a debug
// packet to the IFU, waits for ack or timeout, and holds the response until
// the CSR unit takes it.
module el2_ic_debug_seq
  import el2_ic_debug_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = EL2_IC_DBG_TIMEOUT_CYC,
  parameter int TO_W        = EL2_IC_DBG_TO_W
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [EL2_IC_DICAWICS_W-1:0] req_dicawics,
  input  logic [EL2_IC_WRDATA_W-1:0]   req_wrdata,
  input  logic                         icache_enable,
  input  logic                         abort,
  output el2_cache_debug_pkt_t         dbg_pkt,
  input  logic                         ifu_ack,
  input  logic [EL2_IC_WRDATA_W-1:0]   ifu_rddata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_err,
  output logic [EL2_IC_WRDATA_W-1:0]   rsp_rddata,
  output logic                         busy
);

  el2_ic_dbg_state_t state_q, state_d;
  el2_ic_dbg_req_t   req_q, req_d;
  el2_ic_dbg_rsp_t   rsp_q, rsp_d;
  logic              rdy_q;
  logic              accept;
  logic              tmr_clr, tmr_en, tmr_exp;

  // rdy_q keeps req_ready low for the first cycle out of reset.
  assign req_ready = rdy_q & (state_q == IDLE) & ~abort;
  assign accept    = req_valid & req_ready;

  el2_ic_debug_seq_tmr #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_tmr (
    .clk      (clk),
    .rst_l    (rst_l),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  // Next-state, request/response latch updates and timer control.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d.write    = req_write;
          req_d.dicawics = req_dicawics;
          req_d.wrdata   = req_wrdata;
          rsp_d          = '0;
          if (icache_enable) begin
            state_d = ISSUE;
          end else begin
            // Disabled icache: answer with an error, never touch the IFU.
            state_d   = RESP;
            rsp_d.err = 1'b1;
          end
        end
      end
      ISSUE: begin
        // The packet pulse goes out this cycle regardless of abort.
        tmr_clr = 1'b1;
        state_d = abort ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ifu_ack) begin
          // Ack beats a coincident timeout.
          state_d      = RESP;
          rsp_d.err    = 1'b0;
          rsp_d.rddata = req_q.write ? '0 : ifu_rddata;
        end else if (tmr_exp) begin
          state_d      = RESP;
          rsp_d.err    = 1'b1;
          rsp_d.rddata = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RESP: begin
        // abort is ignored here so the response is always delivered.
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, ready gate and request/response latches.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
    end
  end

  // Debug packet: data fields always reflect the latch, valids only in ISSUE.
  always_comb begin
    dbg_pkt                 = '0;
    dbg_pkt.icache_wrdata   = req_q.wrdata;
    dbg_pkt.icache_dicawics = req_q.dicawics;
    dbg_pkt.icache_rd_valid = (state_q == ISSUE) & ~req_q.write;
    dbg_pkt.icache_wr_valid = (state_q == ISSUE) &  req_q.write;
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_err    = rsp_valid & rsp_q.err;
  assign rsp_rddata = rsp_valid ? rsp_q.rddata : '0;
  assign busy       = (state_q != IDLE);

endmodule
